// File: rtl/apb_master_bridge_if.sv
// Signal bundle between the core-side req/gnt/rvalid port plus APB bus and the bridge.
// The master modport is the bridge's view; slave is the view of the core and APB slave.
interface apb_master_bridge_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 12
);
    // core-side data port
    logic                      req_i;
    logic [ADDR_WIDTH-1:0]     addr_i;
    logic                      we_i;
    logic [31:0]               wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [31:0]               rdata_o;
    logic                      err_o;
    // APB bus
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
        output gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );

    modport slave (
        output req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
        input  gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Core req/gnt/rvalid port to APB master bridge, one transfer outstanding at a time.
// Optional ACCESS-phase timeout abort is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      rvalid_q, rvalid_d;
`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0]               cnt_q, cnt_d;
`endif

    // Upper address bits are decoded by the interconnect, not here.
    logic unused_cfg;
    assign unused_cfg = ^{bus.addr_i[ADDR_WIDTH-1:APB_ADDR_WIDTH], 16'(TIMEOUT_CYCLES)};

    // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rvalid_d = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    paddr_d  = bus.addr_i[APB_ADDR_WIDTH-1:0];
                    pwdata_d = bus.wdata_i;
                    pwrite_d = bus.we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_q ? 32'h0 : bus.PRDATA;
                    err_d    = bus.PSLVERR;
                    state_d  = IDLE;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // This is the TIMEOUT_CYCLES-th wait cycle: give up and report an error.
                else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    rvalid_d = 1'b1;
                    rdata_d  = 32'h0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    // PSEL/PENABLE decode straight from the state register so reset drops them at once.
    assign bus.gnt_o    = (state_q == IDLE) && bus.req_i;
    assign bus.PSEL     = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.PENABLE  = (state_q == ACCESS);
    assign bus.PADDR    = paddr_q;
    assign bus.PWDATA   = pwdata_q;
    assign bus.PWRITE   = pwrite_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a core-side req/gnt/rvalid data port into an APB master. Drives the same APB bus that the event, interrupt and sleep slave units respond on. Exactly one transfer is outstanding at a time. The slave response (read data and error) is returned to the requester as a one-cycle rvalid pulse.

Parameters:
ADDR_WIDTH, 32, width of the core-side address.
APB_ADDR_WIDTH, 12, width of PADDR; driven from addr_i[APB_ADDR_WIDTH-1:0].
TIMEOUT_CYCLES, 255, maximum number of ACCESS cycles before abort. Used only with APB_MASTER_TIMEOUT_EN; must be 1..65535.

Ports:
HCLK  in  1  clock; all logic on the rising edge.
HRESETn  in  1  asynchronous active-low reset.
req_i  in  1  core requests a transfer.
addr_i  in  ADDR_WIDTH  byte address.
we_i  in  1  1 = write, 0 = read.
wdata_i  in  32  write data.
gnt_o  out  1  request accepted this cycle.
rvalid_o  out  1  one-cycle response strobe.
rdata_o  out  32  read data; 0 for writes.
err_o  out  1  transfer failed (PSLVERR or timeout); qualified by rvalid_o.
PADDR  out  APB_ADDR_WIDTH  APB address.
PWDATA  out  32  APB write data.
PWRITE  out  1  APB direction.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PRDATA  in  32  slave read data.
PREADY  in  1  slave ready.
PSLVERR  in  1  slave error.

Behaviour:
- Clock and reset: one clock (HCLK); reset HRESETn is asynchronous, active-low.
- Reset values: all outputs 0; FSM in IDLE; address/data/direction registers 0.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - gnt_o = req_i (combinational, IDLE only).
  - On req_i: latch addr_i[APB_ADDR_WIDTH-1:0], we_i, wdata_i into PADDR/PWRITE/PWDATA registers; go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS.
  - PREADY=1: register rdata = PWRITE ? 0 : PRDATA and err = PSLVERR; go to IDLE.
- Response timing: rvalid_o=1 for exactly one cycle, the cycle after the PREADY=1 sample; rdata_o/err_o valid in that cycle.
- rdata_o/err_o hold their values until the next response; they are meaningful only while rvalid_o=1.
- Latency:
  - Zero-wait slave: gnt at cycle 0, SETUP at 1, ACCESS at 2, rvalid at 3.
  - Each PREADY-low cycle adds one.
- Back-to-back: the rvalid cycle is an IDLE cycle, so a new gnt may coincide with rvalid_o. Sustained throughput is one transfer per 3 cycles.
- APB stability:
  - PADDR, PWRITE, PWDATA do not change from SETUP through the end of ACCESS.
  - They also hold their last values in IDLE and change only on a grant.
- Core-side inputs are don't-care while not in IDLE; no gnt_o is issued outside IDLE.
- PSLVERR is sampled only when PREADY=1 in ACCESS.
- Reset mid-transfer: PSEL/PENABLE drop immediately; the transfer is discarded with no rvalid_o; FSM returns to IDLE.
- Address bits above APB_ADDR_WIDTH are ignored; decoding is done by the interconnect.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - If the counter reaches TIMEOUT_CYCLES with PREADY still 0: abort the transfer, drop PSEL/PENABLE, go to IDLE.
  - The abort produces rvalid_o=1, err_o=1, rdata_o=0 the following cycle.
  - PREADY=1 in the same cycle the limit is reached takes priority: normal completion.
- Undefined: no counter; ACCESS waits on PREADY indefinitely.

Test Plan:
1. Zero-wait read: req at addr 0x004, PREADY tied 1, PRDATA=0xDEADBEEF -> gnt cycle 0; PSEL=1/PENABLE=0 cycle 1; PENABLE=1 cycle 2; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 cycle 3.
2. Write with 3 wait states: we=1, addr 0x100, wdata 0x00000003, PREADY low 3 ACCESS cycles -> PADDR/PWDATA stable throughout; rvalid at cycle 6; rdata_o=0, err_o=0.
3. Slave error: read with PSLVERR=1 alongside PREADY -> rvalid_o=1, err_o=1; next transfer with PSLVERR=0 returns err_o=0.
4. Back-to-back: req held high for 3 transfers, zero-wait -> gnts at cycles 0, 3, 6; rvalids at 3, 6, 9; gnt and rvalid coincide at 3 and 6.
5. Reset mid-ACCESS: assert HRESETn=0 while PREADY=0 -> PSEL/PENABLE/rvalid_o go 0 asynchronously; after release, the first new req gets gnt and completes normally.
6. (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4) PREADY never asserted -> 4 ACCESS cycles, then IDLE; rvalid_o=1, err_o=1, rdata_o=0. Same run with PREADY rising on the 4th cycle -> normal completion, err_o=0.
